// File: rtl/tick_scheduler_pkg.sv
// Shared definitions for the tick scheduler: defaults, command and FSM encodings.
package tick_scheduler_pkg;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 27;

  typedef enum logic [1:0] {
    CMD_SET_PERIOD = 2'b00,
    CMD_START      = 2'b01,
    CMD_STOP       = 2'b10,
    CMD_SYNC_ALL   = 2'b11
  } cfg_cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } cfg_state_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: period/counter/run/clk_out state, reload and tick decode.
module tick_channel #(
  parameter int W = 27
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         set_period,
  input  logic         start,
  input  logic         sync,
  input  logic         stop,
  input  logic [W-1:0] period_in,
  output logic         tick,
  output logic         clk_out,
  output logic         running
);

  logic [W-1:0] period;
  logic [W-1:0] cnt;
  logic         run;
  logic         clk_q;
  logic         restart;

  // SYNC_ALL only restarts channels that are already running.
  assign restart = start | (sync & run);

  // Period register; a write coincident with a reload leaves the reload on the old value.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)          period <= '0;
    else if (set_period) period <= period_in;
  end

  // Counter/run/clk_out: commands override the free-running reload path.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      run   <= 1'b0;
      clk_q <= 1'b0;
    end else if (restart) begin
      if (period != '0) begin
        cnt   <= period - W'(1);
        clk_q <= 1'b0;
        run   <= 1'b1;
      end else begin
        run   <= 1'b0;
      end
    end else if (stop) begin
      run <= 1'b0;
    end else if (run) begin
      if (cnt == '0) begin
        // A zero period stops the channel instead of wrapping the counter.
        if (period == '0) begin
          run <= 1'b0;
        end else begin
          cnt   <= period - W'(1);
          clk_q <= ~clk_q;
        end
      end else begin
        cnt <= cnt - W'(1);
      end
    end
  end

  assign tick    = run & (cnt == '0);
  assign clk_out = clk_q;
  assign running = run;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: two-state config FSM feeding NCH tick channels.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF,
  localparam int CW = ch_width(NCH)
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_cmd,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_period,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] running
);

  cfg_state_e    state, state_nxt;
  cfg_cmd_e      cmd_q;
  logic [CW-1:0] ch_q;
  logic [W-1:0]  period_q;
  logic          accept;
  logic          exec;

  assign cfg_ready = (state == ST_IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign exec      = (state == ST_EXEC);

  // FSM state register; reset drops any captured-but-unexecuted command.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: accept in IDLE, execute for exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cfg_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request on handshake so inputs need not be held.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= CMD_SET_PERIOD;
      ch_q     <= '0;
      period_q <= '0;
    end else if (accept) begin
      cmd_q    <= cfg_cmd_e'(cfg_cmd);
      ch_q     <= cfg_ch;
      period_q <= cfg_period;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic hit;
    assign hit = (ch_q == CW'(g));

    tick_channel #(.W(W)) u_ch (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .set_period (exec && cmd_q == CMD_SET_PERIOD && hit),
      .start      (exec && cmd_q == CMD_START && hit),
      .sync       (exec && cmd_q == CMD_SYNC_ALL),
      .stop       (exec && cmd_q == CMD_STOP && hit),
      .period_in  (period_q),
      .tick       (tick[g]),
      .clk_out    (clk_out[g]),
      .running    (running[g])
    );
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent tick channels.
REQ-002 SHALL have parameter W, default 27, meaning period/counter width in bits.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_valid  input  1  config request valid.
REQ-006 SHALL have port cfg_ready  output  1  config request accepted when high with cfg_valid.
REQ-007 SHALL have port cfg_cmd  input  2  command: 00 SET_PERIOD, 01 START, 10 STOP, 11 SYNC_ALL.
REQ-008 SHALL have port cfg_ch  input  log2(NCH)  target channel (ignored by SYNC_ALL).
REQ-009 SHALL have port cfg_period  input  W  period value (used by SET_PERIOD only).
REQ-010 SHALL have port tick  output  NCH  per-channel one-cycle enable pulse.
REQ-011 SHALL have port clk_out  output  NCH  per-channel square wave, toggles on each tick.
REQ-012 SHALL have port running  output  NCH  per-channel RUN status.

Function
REQ-013 Config FSM SHALL have states IDLE and EXEC; cfg_ready = 1 only in IDLE.
REQ-014 Handshake SHALL complete at edge E0 when cfg_valid & cfg_ready; cmd/ch/period captured; FSM -> EXEC.
REQ-015 Command SHALL take effect at edge E1 (next edge); FSM EXEC -> IDLE at E1; max one command per 2 cycles.
REQ-016 cfg_valid while cfg_ready low SHALL be ignored; inputs need not be held after E0.
REQ-017 Each channel SHALL hold period[W-1:0], cnt[W-1:0], run, clk_out state.
REQ-018 SET_PERIOD SHALL write period[ch] at E1; cnt and run unchanged; new value used at next reload.
REQ-019 START SHALL at E1: if period[ch] != 0, cnt <= period-1, clk_out[ch] <= 0, run <= 1; if period[ch] == 0, run <= 0 (no-op otherwise).
REQ-020 START on a running channel SHALL restart it identically (phase reset).
REQ-021 STOP SHALL at E1 set run <= 0; cnt and clk_out hold; tick forced 0.
REQ-022 SYNC_ALL SHALL at E1 apply the START rule to every channel with run = 1; idle channels unaffected.
REQ-023 tick[ch] SHALL equal run & (cnt == 0), decoded from registers (no cfg input paths).
REQ-024 While run: cnt == 0 -> reload cnt <= period-1 and toggle clk_out; else cnt <= cnt-1.
REQ-025 Reload with period == 0 SHALL set run <= 0 and not toggle clk_out (no underflow wrap).
REQ-026 Tick spacing SHALL be exactly period cycles; first tick high in the period-th cycle after E1; period = 1 gives tick constantly high, clk_out toggling every cycle.
REQ-027 Command at E1 on same channel as a reload edge: START/STOP/SYNC_ALL SHALL override the reload; SET_PERIOD coincident with reload SHALL let the reload use the old period.
REQ-028 running[ch] SHALL equal run; all outputs registered-state decodes only.

Reset
REQ-029 rst_n low SHALL immediately force: FSM IDLE, cfg_ready 1 after release, all period/cnt 0, run 0, tick 0, clk_out 0, running 0.
REQ-030 Reset mid-command (between E0 and E1) SHALL discard the captured command.

Structure
REQ-031 Shared package SHALL hold W and NCH defaults, cfg_cmd encodings, and FSM state encodings.
REQ-032 Per-channel logic SHALL be one sub-module tick_channel (period/cnt/run/clk_out, reload, tick decode), instantiated NCH times via generate.

Verification
REQ-033 SET_PERIOD ch0=3, START ch0 -> first tick 3 cycles after E1, then every 3 cycles; clk_out[0] period 6 cycles.
REQ-034 SET_PERIOD ch1=1, START ch1 -> tick[1] constantly high, clk_out[1] toggles every cycle; STOP ch1 -> tick[1]=0, running[1]=0 at E1.
REQ-035 ch0 running period 5, SET_PERIOD ch0=2 mid-count -> current interval stays 5, subsequent intervals 2.
REQ-036 START ch2 with period 0 -> running[2] stays 0, no ticks; running ch3 SET_PERIOD 0 -> ch3 stops at next reload, no extra clk_out toggle.
REQ-037 ch0 (period 4) and ch1 (period 7) running out of phase, SYNC_ALL -> both restart at E1, coincident ticks every 28 cycles; ch2 idle unaffected.
REQ-038 Back-to-back cfg_valid -> cfg_ready low in EXEC, second request accepted 2 cycles after first; rst_n pulsed between E0 and E1 -> command lost, all outputs 0.
